// File: rtl/toy_pack.sv
// Shared icache widths plus the data-RAM command bundle used by the data-RAM arbiter.
package toy_pack;

    localparam int ICACHE_INDEX_WIDTH     = 9;
    localparam int ICACHE_DATA_WIDTH      = 64;
    localparam int ICACHE_REQ_TXNID_WIDTH = 4;
    localparam int MSHR_ENTRY_INDEX_WIDTH = 3;

    // Data-RAM address is {way, index}
    localparam int ICACHE_DARB_RAM_ADDR_WIDTH = ICACHE_INDEX_WIDTH + 1;

    typedef struct packed {
        logic                                  wr;
        logic [ICACHE_DARB_RAM_ADDR_WIDTH-1:0] addr;
        logic [ICACHE_DATA_WIDTH-1:0]          wdata;
    } dataram_cmd_t;

    function automatic dataram_cmd_t mk_dataram_cmd(
        input logic                          wr,
        input logic                          way,
        input logic [ICACHE_INDEX_WIDTH-1:0] index,
        input logic [ICACHE_DATA_WIDTH-1:0]  wdata
    );
        dataram_cmd_t c;
        c.wr    = wr;
        c.addr  = {way, index};
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/icache_dataram_arb.sv
// Single-port icache data-RAM arbiter: refill writes beat hit reads, with optional
// read-starvation relief when ICACHE_DARB_STARVE_EN is defined.
module icache_dataram_arb
    import toy_pack::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int RAM_ADDR_WIDTH = ICACHE_INDEX_WIDTH + 1
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              rd_req_vld,
    output logic                              rd_req_rdy,
    input  logic [ICACHE_INDEX_WIDTH-1:0]     rd_req_index,
    input  logic                              rd_req_way,
    input  logic [ICACHE_REQ_TXNID_WIDTH-1:0] rd_req_txnid,

    input  logic                              wr_req_vld,
    output logic                              wr_req_rdy,
    input  logic [ICACHE_INDEX_WIDTH-1:0]     wr_req_index,
    input  logic                              wr_req_way,
    input  logic [ICACHE_DATA_WIDTH-1:0]      wr_req_data,
    input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] wr_req_entry_idx,

    output logic                              ram_en,
    output logic                              ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_addr,
    output logic [ICACHE_DATA_WIDTH-1:0]      ram_wdata,
    input  logic [ICACHE_DATA_WIDTH-1:0]      ram_rdata,

    output logic                              rd_rsp_vld,
    output logic [ICACHE_DATA_WIDTH-1:0]      rd_rsp_data,
    output logic [ICACHE_REQ_TXNID_WIDTH-1:0] rd_rsp_txnid,

    output logic                              wr_done_vld,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] wr_done_entry_idx
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic         starve;
    logic         rd_gnt;
    logic         wr_gnt;
    dataram_cmd_t cmd;

    logic                              rd_rsp_vld_q;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] rd_rsp_txnid_q;
    logic                              wr_done_vld_q;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] wr_done_entry_idx_q;

`ifdef ICACHE_DARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    assign starve = (starve_cnt_q == LIMIT);

    // Counts writes that overtook a waiting read; any read grant or idle read resets it
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (rd_gnt || !rd_req_vld) begin
            starve_cnt_d = '0;
        end else if (wr_gnt && !starve) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve = 1'b0;
`endif

    assign rd_req_rdy = !wr_req_vld || starve;
    assign wr_req_rdy = !(starve && rd_req_vld);

    // The two grants are mutually exclusive by construction of the ready terms
    assign rd_gnt = rd_req_vld && rd_req_rdy && !rst;
    assign wr_gnt = wr_req_vld && wr_req_rdy && !rst;

    always_comb begin
        cmd = '0;
        if (wr_gnt) begin
            cmd = mk_dataram_cmd(1'b1, wr_req_way, wr_req_index, wr_req_data);
        end else if (rd_gnt) begin
            cmd = mk_dataram_cmd(1'b0, rd_req_way, rd_req_index, '0);
        end
    end

    assign ram_en    = rd_gnt || wr_gnt;
    assign ram_wr    = cmd.wr;
    assign ram_addr  = RAM_ADDR_WIDTH'(cmd.addr);
    assign ram_wdata = cmd.wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_rsp_vld_q        <= 1'b0;
            rd_rsp_txnid_q      <= '0;
            wr_done_vld_q       <= 1'b0;
            wr_done_entry_idx_q <= '0;
        end else begin
            rd_rsp_vld_q  <= rd_gnt;
            wr_done_vld_q <= wr_gnt;
            if (rd_gnt) begin
                rd_rsp_txnid_q <= rd_req_txnid;
            end
            if (wr_gnt) begin
                wr_done_entry_idx_q <= wr_req_entry_idx;
            end
        end
    end

    // RAM returns read data one cycle after the command, aligned with rd_rsp_vld
    assign rd_rsp_vld        = rd_rsp_vld_q;
    assign rd_rsp_data       = ram_rdata;
    assign rd_rsp_txnid      = rd_rsp_txnid_q;
    assign wr_done_vld       = wr_done_vld_q;
    assign wr_done_entry_idx = wr_done_entry_idx_q;

endmodule

// File: doc/icache_dataram_arb.md
ICACHE_DATARAM_ARB -- requirements
Module: icache_dataram_arb

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive write grants allowed while a read waits (range 1..15).
REQ-002 Parameter: RAM_ADDR_WIDTH, default ICACHE_INDEX_WIDTH+1, data-RAM address {way,index}.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rd_req_vld / rd_req_rdy  input / output  1 / 1  hit-read request handshake.
REQ-006 rd_req_index, rd_req_way, rd_req_txnid  input  ICACHE_INDEX_WIDTH / 1 / ICACHE_REQ_TXNID_WIDTH  read target and tag.
REQ-007 wr_req_vld / wr_req_rdy  input / output  1 / 1  MSHR refill-write handshake.
REQ-008 wr_req_index, wr_req_way, wr_req_data, wr_req_entry_idx  input  ICACHE_INDEX_WIDTH / 1 / ICACHE_DATA_WIDTH / MSHR_ENTRY_INDEX_WIDTH  refill target, line and owning MSHR entry.
REQ-009 ram_en, ram_wr, ram_addr, ram_wdata  output  1 / 1 / RAM_ADDR_WIDTH / ICACHE_DATA_WIDTH  single-port data-RAM command.
REQ-010 ram_rdata  input  ICACHE_DATA_WIDTH  RAM read data, valid one cycle after a read command.
REQ-011 rd_rsp_vld, rd_rsp_data, rd_rsp_txnid  output  1 / ICACHE_DATA_WIDTH / ICACHE_REQ_TXNID_WIDTH  read response, no back-pressure.
REQ-012 wr_done_vld, wr_done_entry_idx  output  1 / MSHR_ENTRY_INDEX_WIDTH  refill-write completion to MSHR.

Function
- REQ-013 At most one RAM access per cycle; a request is granted when vld&&rdy in that cycle.
- REQ-014 Grant is combinational in the request cycle; ram_en/ram_wr/ram_addr/ram_wdata driven in the same cycle (ram_addr = {way,index}).
- REQ-015 Default priority: write over read.
- REQ-016 starve_cnt (4 bits) increments on each write grant while rd_req_vld=1, saturating at STARVE_LIMIT; clears on any read grant or when rd_req_vld=0.
- REQ-017 When starve_cnt==STARVE_LIMIT and both requests valid, read is granted and write waits.
- REQ-018 Only one valid: that requester is granted immediately, counter rules unchanged.
- REQ-019 Read response: rd_rsp_vld asserts exactly 1 cycle after read grant, rd_rsp_data=ram_rdata, rd_rsp_txnid registered from grant cycle.
- REQ-020 Write completion: wr_done_vld pulses 1 cycle after write grant with registered entry_idx.
- REQ-021 Back-to-back grants every cycle are supported; no bubble between read and write.
- REQ-022 Neither valid: ram_en=0, rdy outputs follow REQ-015/017 (rd_req_rdy = !wr_req_vld || starve; wr_req_rdy = !(starve && rd_req_vld)).
- REQ-023 Read to same {way,index} granted the cycle after a write shall return the newly written data (RAM write-first ordering, no internal bypass).

Reset
- REQ-024 During rst: starve_cnt=0, rd_rsp_vld=0, wr_done_vld=0, rd_rsp_txnid=0, wr_done_entry_idx=0, ram_en=0.
- REQ-025 Reset mid-operation drops any in-flight response/completion; no pulse after deassertion.

Configuration
- REQ-026 Macro ICACHE_DARB_STARVE_EN defined: starvation counter and REQ-016/017 present.
- REQ-027 Undefined: strict write priority, no counter flops, rd_req_rdy = !wr_req_vld.

Structure
- REQ-028 ICACHE_INDEX_WIDTH, ICACHE_DATA_WIDTH, ICACHE_REQ_TXNID_WIDTH, MSHR_ENTRY_INDEX_WIDTH come from toy_pack; a new typedef dataram_cmd_t {wr, addr, wdata} shall be added there.
- REQ-029 Single module, no sub-modules; grant logic combinational, counter and response pipeline sequential.

Verification
- REQ-030 Read only, index=0x1A5 way=1 txnid=7 -> ram_addr=0x3A5, ram_wr=0; next cycle rd_rsp_vld=1, txnid=7.
- REQ-031 Write only, entry_idx=3 -> ram_wr=1 same cycle; next cycle wr_done_vld=1, wr_done_entry_idx=3.
- REQ-032 Both valid continuously, STARVE_LIMIT=4, macro on -> grant pattern W,W,W,W,R repeating.
- REQ-033 Same as REQ-032 with macro off -> read never granted until wr_req_vld drops.
- REQ-034 Write 0xAA.. to {1,0x010}, read same address next cycle -> rd_rsp_data=0xAA...
- REQ-035 Assert rst the cycle after a read grant -> rd_rsp_vld stays 0, starve_cnt=0 after release.
